// File: rtl/flip_icon_loader.sv
// flip_icon_loader: packs a narrow host word stream into NUM_SPIN-bit flip
// icons and writes each completed icon to consecutive icon-memory addresses.
// The number of icons loaded is published as the flip engine's end marker.
module flip_icon_loader #(
  parameter int NUM_SPIN             = 256,
  parameter int FLIP_ICON_DEPTH      = 1024,
  parameter int FLIP_ICON_ADDR_DEPTH = $clog2(FLIP_ICON_DEPTH),
  parameter int DATAW                = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic                            flush_i,
  input  logic                            load_start_i,
  input  logic                            host_valid_i,
  input  logic [DATAW-1:0]                host_data_i,
  input  logic                            host_last_i,
  output logic                            host_ready_o,
  output logic                            icon_wen_o,
  output logic [FLIP_ICON_ADDR_DEPTH-1:0] icon_waddr_o,
  output logic [NUM_SPIN-1:0]             icon_wdata_o,
  output logic [FLIP_ICON_ADDR_DEPTH:0]   icon_last_raddr_plus_one_o,
  output logic                            load_busy_o,
  output logic                            load_done_o,
  output logic                            load_err_o
);

  localparam int WORDS_PER_ICON = NUM_SPIN / DATAW;
  localparam int WCNT_W         = (WORDS_PER_ICON > 1) ? $clog2(WORDS_PER_ICON) : 1;
  localparam int CNT_W          = FLIP_ICON_ADDR_DEPTH + 1;

  localparam logic [WCNT_W-1:0] LAST_LANE = WCNT_W'(WORDS_PER_ICON - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FLIP_ICON_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]    icon_cnt_q, icon_cnt_d;
  logic                last_q, last_d;
  logic [NUM_SPIN-1:0] asm_q, asm_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    count_q, count_d;

  // State and datapath registers; all next values come from the process below.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      icon_cnt_q <= '0;
      last_q     <= 1'b0;
      // NOTE: the assembly register is reset on purpose; short icons rely on
      // unwritten lanes already being zero instead of masking them on write.
      asm_q      <= '0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values computed for the previous cycle.
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      icon_cnt_q <= icon_cnt_d;
      last_q     <= last_d;
      asm_q      <= asm_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  // Next-state, datapath updates and the write-port decode of the loader FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    icon_cnt_d   = icon_cnt_q;
    last_d       = last_q;
    asm_d        = asm_q;
    err_d        = err_q;
    count_d      = count_q;
    host_ready_o = 1'b0;
    icon_wen_o   = 1'b0;
    icon_waddr_o = '0;
    icon_wdata_o = '0;

    if (flush_i) begin
      // Flush wins over enable, load start and any handshake this cycle.
      state_d    = S_IDLE;
      word_cnt_d = '0;
      icon_cnt_d = '0;
      last_d     = 1'b0;
      asm_d      = '0;
      err_d      = 1'b0;
      count_d    = '0;
    end else if (en_i) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (load_start_i) begin
            state_d    = S_LOAD;
            word_cnt_d = '0;
            icon_cnt_d = '0;
            last_d     = 1'b0;
            err_d      = 1'b0;
          end
        end

        S_LOAD: begin
          host_ready_o = 1'b1;
          if (host_valid_i) begin
            asm_d[word_cnt_q * DATAW +: DATAW] = host_data_i;
            if ((word_cnt_q == LAST_LANE) || host_last_i) begin
              last_d  = host_last_i;
              state_d = S_WRITE;
              // A last marker before the final lane ends a short icon.
              if (word_cnt_q != LAST_LANE) begin
                err_d = 1'b1;
              end
            end else begin
              word_cnt_d = word_cnt_q + WCNT_W'(1);
            end
          end
        end

        S_WRITE: begin
          if (icon_cnt_q < DEPTH_CNT) begin
            icon_wen_o   = 1'b1;
            icon_waddr_o = icon_cnt_q[FLIP_ICON_ADDR_DEPTH-1:0];
            icon_wdata_o = asm_q;
            icon_cnt_d   = icon_cnt_q + CNT_W'(1);
            state_d      = last_q ? S_DONE : S_LOAD;
          end else begin
            // Icon memory is full: drop the icon and end the load.
            err_d   = 1'b1;
            state_d = S_DONE;
          end
          word_cnt_d = '0;
          asm_d      = '0;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase

      // The published icon count is captured only on entry to DONE.
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
        count_d = icon_cnt_d;
      end
    end
  end

  assign icon_last_raddr_plus_one_o = count_q;
  assign load_busy_o                = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign load_done_o                = (state_q == S_DONE);
  assign load_err_o                 = err_q;

endmodule

// File: tb/tb_flip_icon_loader.sv
// tb_flip_icon_loader: directed bench for flip_icon_loader. A reference model
// packs the words it drives into icons and queues the expected writes; a
// monitor pops and compares them whenever the DUT writes the icon memory.
module tb_flip_icon_loader;

  localparam int NUM_SPIN    = 256;
  localparam int DATAW       = 32;
  localparam int WPI         = NUM_SPIN / DATAW;
  localparam int DEPTH       = 1024;
  localparam int ADDR        = 10;
  localparam int SMALL_DEPTH = 2;
  localparam int SMALL_ADDR  = 1;

  typedef struct {
    int                  addr;
    logic [NUM_SPIN-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic load_start = 1'b0;
  logic host_valid = 1'b0;
  logic host_last = 1'b0;
  logic [DATAW-1:0] host_data = '0;
  logic en_main = 1'b1;
  logic en_small = 1'b0;
  logic sel_small = 1'b0;

  logic                ready_m, wen_m, busy_m, done_m, err_m;
  logic [ADDR-1:0]     waddr_m;
  logic [NUM_SPIN-1:0] wdata_m;
  logic [ADDR:0]       count_m;

  logic                  ready_s, wen_s, busy_s, done_s, err_s;
  logic [SMALL_ADDR-1:0] waddr_s;
  logic [NUM_SPIN-1:0]   wdata_s;
  logic [SMALL_ADDR:0]   count_s;

  logic ready_act, wen_act, busy_act, done_act;

  wr_t exp_m[$];
  wr_t exp_s[$];

  logic [NUM_SPIN-1:0] m_acc;
  int m_lane;
  int m_icon;
  int passed = 0;
  int total = 0;

  flip_icon_loader dut (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .en_i                       (en_main),
    .flush_i                    (flush),
    .load_start_i               (load_start),
    .host_valid_i               (host_valid),
    .host_data_i                (host_data),
    .host_last_i                (host_last),
    .host_ready_o               (ready_m),
    .icon_wen_o                 (wen_m),
    .icon_waddr_o               (waddr_m),
    .icon_wdata_o               (wdata_m),
    .icon_last_raddr_plus_one_o (count_m),
    .load_busy_o                (busy_m),
    .load_done_o                (done_m),
    .load_err_o                 (err_m)
  );

  flip_icon_loader #(.FLIP_ICON_DEPTH(SMALL_DEPTH)) dut_small (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .en_i                       (en_small),
    .flush_i                    (flush),
    .load_start_i               (load_start),
    .host_valid_i               (host_valid),
    .host_data_i                (host_data),
    .host_last_i                (host_last),
    .host_ready_o               (ready_s),
    .icon_wen_o                 (wen_s),
    .icon_waddr_o               (waddr_s),
    .icon_wdata_o               (wdata_s),
    .icon_last_raddr_plus_one_o (count_s),
    .load_busy_o                (busy_s),
    .load_done_o                (done_s),
    .load_err_o                 (err_s)
  );

  assign ready_act = sel_small ? ready_s : ready_m;
  assign wen_act   = sel_small ? wen_s   : wen_m;
  assign busy_act  = sel_small ? busy_s  : busy_m;
  assign done_act  = sel_small ? done_s  : done_m;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NUM_SPIN-1:0] obs,
                       input logic [NUM_SPIN-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard pop for the default-depth instance.
  always @(negedge clk) begin
    wr_t e;
    if (wen_m === 1'b1) begin
      check("ready_low_in_write_m", ready_m, 0);
      check("write_expected_m", exp_m.size(), 1);
      if (exp_m.size() != 0) begin
        e = exp_m.pop_front();
        check("waddr_m", waddr_m, e.addr);
        check("wdata_m", wdata_m, e.data);
      end
    end
  end

  // Scoreboard pop for the two-entry instance.
  always @(negedge clk) begin
    wr_t e;
    if (wen_s === 1'b1) begin
      check("ready_low_in_write_s", ready_s, 0);
      check("write_expected_s", exp_s.size(), 1);
      if (exp_s.size() != 0) begin
        e = exp_s.pop_front();
        check("waddr_s", waddr_s, e.addr);
        check("wdata_s", wdata_s, e.data);
      end
    end
  end

  task automatic start_load();
    @(posedge clk); #1;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    m_acc  = '0;
    m_lane = 0;
    m_icon = 0;
    check("busy_after_start", busy_act, 1);
  endtask

  // Drives words base+k; the model packs them and queues the expected writes.
  task automatic send_stream(input int nwords, input int base, input bit gaps,
                             input bit last_final);
    int  waits;
    int  gap;
    int  depth;
    bit  is_last;
    wr_t e;
    depth = sel_small ? SMALL_DEPTH : DEPTH;
    for (int k = 0; k < nwords; k++) begin
      is_last = last_final && (k == nwords - 1);
      if (gaps) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin @(posedge clk); #1; end
      end
      host_valid = 1'b1;
      host_data  = DATAW'(base + k);
      host_last  = is_last;
      waits = 0;
      @(negedge clk);
      while (ready_act !== 1'b1 && waits < 50) begin
        @(negedge clk);
        waits++;
      end
      check("ready_wait", ready_act, 1);
      if (ready_act !== 1'b1) begin
        host_valid = 1'b0;
        host_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
      host_valid = 1'b0;
      host_last  = 1'b0;
      m_acc[m_lane*DATAW +: DATAW] = DATAW'(base + k);
      if (m_lane == WPI - 1 || is_last) begin
        if (m_icon < depth) begin
          e.addr = m_icon;
          e.data = m_acc;
          if (sel_small) exp_s.push_back(e);
          else exp_m.push_back(e);
          check("wen_latency", wen_act, 1);
          m_icon++;
        end else begin
          check("overflow_no_write", wen_act, 0);
        end
        m_acc  = '0;
        m_lane = 0;
      end else begin
        m_lane++;
      end
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (done_act !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", done_act, 1);
  endtask

  task automatic check_main_zero(input string tag);
    check({tag, "_wen"}, wen_m, 0);
    check({tag, "_waddr"}, waddr_m, 0);
    check({tag, "_wdata"}, wdata_m, 0);
    check({tag, "_ready"}, ready_m, 0);
    check({tag, "_busy"}, busy_m, 0);
    check({tag, "_done"}, done_m, 0);
    check({tag, "_count"}, count_m, 0);
    check({tag, "_err"}, err_m, 0);
  endtask

  task automatic check_result(input string tag, input int count, input bit err);
    check({tag, "_done"}, done_m, 1);
    check({tag, "_count"}, count_m, count);
    check({tag, "_err"}, err_m, err);
    check({tag, "_all_written"}, exp_m.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #1 rst = 1'b1;
    #2 check_main_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // 1: two full icons, last on word 16.
    start_load();
    send_stream(16, 0, 1'b0, 1'b1);
    wait_done();
    check_result("s1", 2, 1'b0);

    // 2: same stream with random valid gaps.
    start_load();
    send_stream(16, 0, 1'b1, 1'b1);
    wait_done();
    check_result("s2", 2, 1'b0);

    // 3: short icon ended on word 3; upper lanes zero, error flagged.
    start_load();
    send_stream(3, 0, 1'b0, 1'b1);
    wait_done();
    check_result("s3", 1, 1'b1);

    // 4: two-entry memory, three icons streamed.
    @(posedge clk); #1;
    en_main   = 1'b0;
    en_small  = 1'b1;
    sel_small = 1'b1;
    start_load();
    send_stream(24, 'h100, 1'b0, 1'b1);
    wait_done();
    check("s4_done", done_s, 1);
    check("s4_count", count_s, 2);
    check("s4_err", err_s, 1);
    check("s4_all_written", exp_s.size(), 0);
    @(posedge clk); #1;
    en_small  = 1'b0;
    sel_small = 1'b0;
    en_main   = 1'b1;

    // 5a: flush after five words, with a word offered in the flush cycle.
    start_load();
    send_stream(5, 0, 1'b0, 1'b0);
    flush      = 1'b1;
    host_valid = 1'b1;
    host_data  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    flush      = 1'b0;
    host_valid = 1'b0;
    check_main_zero("s5_flush");
    repeat (3) @(negedge clk);
    check("s5_flush_no_write", exp_m.size(), 0);

    // 5b: enable low for four cycles mid-icon while a word is offered.
    start_load();
    send_stream(4, 0, 1'b0, 1'b0);
    en_main    = 1'b0;
    host_valid = 1'b1;
    host_data  = 32'h0000_0004;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s5_en_low_ready", ready_m, 0);
      check("s5_en_low_busy", busy_m, 1);
      @(posedge clk); #1;
    end
    host_valid = 1'b0;
    en_main    = 1'b1;
    send_stream(12, 4, 1'b0, 1'b1);
    wait_done();
    check_result("s5_en", 2, 1'b0);

    // 6: asynchronous reset in the WRITE cycle of the first icon.
    start_load();
    send_stream(8, 'h20, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 check_main_zero("s6_async_rst");
    exp_m.delete();
    @(negedge clk) rst = 1'b0;
    start_load();
    send_stream(16, 0, 1'b0, 1'b1);
    wait_done();
    check_result("s6_reload", 2, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
